// File: rtl/vector_output_streamer.sv
// vector_output_streamer: buffers flagged write-back vectors and
// streams them one element per handshake to a narrow sink.
module vector_output_streamer #(
  parameter int DATA_WIDTH  = 16,
  parameter int VECTOR_SIZE = 6,
  parameter int FIFO_DEPTH  = 4,
  parameter int IDX_WIDTH   = $clog2(VECTOR_SIZE)
) (
  input  logic                              clock,
  input  logic                              reset,
  input  logic [VECTOR_SIZE*DATA_WIDTH-1:0] vectorIn,
  input  logic                              vectorValid,
  output logic [DATA_WIDTH-1:0]             elementOut,
  output logic [IDX_WIDTH-1:0]              elementIndex,
  output logic                              elementValid,
  input  logic                              elementReady,
  output logic                              lastElement,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]   fifoCount,
  output logic                              fifoFull,
  output logic                              overflow
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(FIFO_DEPTH+1);
  localparam logic [IDX_WIDTH-1:0] LAST =
    IDX_WIDTH'(VECTOR_SIZE-1);
  localparam logic [CW-1:0] FULL = CW'(FIFO_DEPTH);

  typedef enum logic {IDLE, SEND} state_t;

  state_t state, state_n;

  logic [VECTOR_SIZE*DATA_WIDTH-1:0] mem [FIFO_DEPTH];
  logic [DATA_WIDTH-1:0] head [VECTOR_SIZE];

  logic [PW-1:0]        wptr, rptr;
  logic [CW-1:0]        count, count_n;
  logic [IDX_WIDTH-1:0] idx;
  logic                 xfer, pop, push, drop;

  assign elementValid = (state == SEND);
  assign fifoCount    = count;
  assign fifoFull     = (count == FULL);
  assign elementIndex = idx;
  assign lastElement  = elementValid & (idx == LAST);

  assign xfer = elementValid & elementReady;
  assign pop  = xfer & (idx == LAST);
  // A pop frees the head slot on the same edge, so a full
  // buffer can still accept a push in that cycle.
  assign push = vectorValid & (~fifoFull | pop);
  assign drop = vectorValid & fifoFull & ~pop;

  // Split the head vector into elements for indexed selection.
  always_comb begin
    for (int k = 0; k < VECTOR_SIZE; k++) begin
      head[k] = mem[rptr][k*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  // Present the current head element, zero while idle.
  always_comb begin
    elementOut = '0;
    if (elementValid) elementOut = head[idx];
  end

  // Occupancy after this edge's push/pop.
  always_comb begin
    count_n = count;
    if (push & ~pop)      count_n = count + CW'(1);
    else if (pop & ~push) count_n = count - CW'(1);
  end

  // Serializer next state follows buffer occupancy.
  always_comb begin
    state_n = state;
    unique case (state)
      IDLE: if (count_n != '0) state_n = SEND;
      SEND: if (count_n == '0) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // Serializer state register.
  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= state_n;
  end

  // Pointers, occupancy, element index and sticky overflow.
  always_ff @(posedge clock) begin
    if (reset) begin
      wptr     <= '0;
      rptr     <= '0;
      count    <= '0;
      idx      <= '0;
      overflow <= 1'b0;
    end else begin
      count <= count_n;
      if (push) wptr <= wptr + PW'(1);
      if (pop)  rptr <= rptr + PW'(1);
      if (xfer) idx  <= pop ? '0 : idx + IDX_WIDTH'(1);
      if (drop) overflow <= 1'b1;
    end
  end

  // Vector storage; a capture in the reset cycle is ignored.
  always_ff @(posedge clock) begin
    if (!reset && push) mem[wptr] <= vectorIn;
  end

endmodule

// File: doc/vector_output_streamer.md
# vector_output_streamer

Output stage downstream of the CPU write-back: captures each vector result the pipeline flags for output (`out`/`outFlag` from write-back), buffers up to FIFO_DEPTH vectors, and streams them element by element over a valid/ready handshake to a narrow sink (display driver, UART bridge or testbench monitor). It decouples the stall-free CPU pipeline from a slower consumer and flags any result lost to back-pressure.

## Interface
Parameters:
- DATA_WIDTH, 16, width of one vector element
- VECTOR_SIZE, 6, elements per vector
- FIFO_DEPTH, 4, vectors buffered; power of two, ≥2
- IDX_WIDTH, $clog2(VECTOR_SIZE), element index width

Ports:
- clock  in  1  single clock; all logic on rising edge
- reset  in  1  synchronous, active-high
- vectorIn  in  VECTOR_SIZE*DATA_WIDTH  result vector; element k = bits [k*DATA_WIDTH +: DATA_WIDTH]
- vectorValid  in  1  capture request (CPU outFlag)
- elementOut  out  DATA_WIDTH  current element of head vector
- elementIndex  out  IDX_WIDTH  index k of elementOut
- elementValid  out  1  elementOut is valid
- elementReady  in  1  sink accepts element
- lastElement  out  1  high while elementIndex == VECTOR_SIZE-1 and elementValid
- fifoCount  out  $clog2(FIFO_DEPTH+1)  vectors stored, including the one being streamed
- fifoFull  out  1  fifoCount == FIFO_DEPTH
- overflow  out  1  sticky: a vectorValid was dropped

## Operation
- Storage: circular buffer of FIFO_DEPTH vectors, write pointer, read pointer (log2 FIFO_DEPTH bits, natural wrap), count register.
- Push: on a rising edge with vectorValid=1, vectorIn written at write pointer, pointer+1, unless full and no pop this cycle.
- Drop: vectorValid=1 while full and no pop → vector discarded, overflow set to 1; overflow clears only on reset.
- Serializer states: IDLE (count==0, elementValid=0) and SEND (count>0, elementValid=1). IDLE→SEND when count becomes nonzero; SEND→IDLE when the last element of the last stored vector is accepted and no push occurs that cycle.
- In SEND: elementOut = head vector element [elementIndex]; elementIndex starts at 0.
- Transfer = elementValid & elementReady. On transfer with index < VECTOR_SIZE-1: index+1. On transfer with index == VECTOR_SIZE-1 (pop): index→0, read pointer+1, count−1.
- Simultaneous push and pop: count unchanged; push accepted even when full (slot freed same edge).
- elementOut/elementIndex held stable while elementValid=1 and elementReady=0.
- Head vector is never overwritten while streaming (write pointer never equals read pointer with count>0 except when full and the push is blocked).
- elementOut, elementIndex: 0 when IDLE.

## Timing
- Reset (synchronous): count=0, pointers=0, elementIndex=0, state IDLE, overflow=0, elementValid=0, lastElement=0, fifoFull=0, elementOut=0. Reset mid-stream discards all stored vectors; vectorValid in the reset cycle is ignored.
- Capture latency: vectorValid sampled at edge N into an empty FIFO → elementValid=1 and element 0 visible from cycle after edge N.
- Throughput: with elementReady held high, one element per cycle; a vector streams in VECTOR_SIZE cycles; next stored vector's element 0 follows immediately with no bubble.
- fifoCount, fifoFull, overflow are registered and update at the edge of the push/pop/drop.
- elementReady may toggle any cycle; elementValid never drops without a transfer except on reset.

## Test plan
- Reset then one push of vectorIn = {16'h0006,16'h0005,16'h0004,16'h0003,16'h0002,16'h0001} with elementReady=1 → elements 1,2,3,4,5,6 on consecutive cycles, indices 0..5, lastElement only with 6, then elementValid=0, fifoCount 1→0.
- Same vector, elementReady toggling 1,0,0,1,… → each element held stable while ready=0; sequence and count unchanged; 6 transfers total.
- Elementready=0, push 5 vectors back-to-back (FIFO_DEPTH=4) → fifoCount=4, fifoFull=1, 5th dropped, overflow=1 and stays 1 after draining; drained data = first 4 vectors in order.
- FIFO full, push coinciding with pop of last element of head → push accepted, fifoCount stays 4, overflow stays 0; new vector streamed last.
- Two vectors pushed, elementReady=1 → 12 consecutive transfers, no bubble between index 5 and index 0 of second vector; pointer wrap exercised by 9 total vectors in a row.
- Reset asserted at element index 3 of a 2-deep FIFO → next cycle elementValid=0, fifoCount=0, overflow=0; a new push afterward streams from index 0.
